imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Write-side counterpart of the instruction memory. Receives a byte stream
//  (valid/ready), assembles little-endian 32-bit words and writes them into the
//  instruction RAM's write port at word addresses 0..N-1. Holds the CPU
//  (cpu_hold) while a program image loads. Sits between the host byte source
//  and the instruction RAM.
// PARAMETERS
//  ADDR_W  11    word-address width of the instruction RAM
//  DEPTH   2048  RAM capacity in words; header counts above DEPTH are rejected
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  rst         in   1       synchronous reset, active-high
//  start       in   1       1-cycle pulse: begin a load (honoured only in IDLE)
//  byte_valid  in   1       byte_data valid
//  byte_data   in   8       stream byte
//  byte_ready  out  1       loader accepts a byte this cycle
//  mem_we      out  1       RAM write enable, 1-cycle pulse per word
//  mem_addr    out  ADDR_W  RAM word address
//  mem_wdata   out  32      RAM write data
//  cpu_hold    out  1       1 while a load is in progress
//  busy        out  1       1 in any state except IDLE
//  done        out  1       1-cycle pulse on successful completion
//  err         out  1       sticky error; cleared by next accepted start
// BEHAVIOUR
//  - Byte transfer = byte_valid & byte_ready on a rising edge.
//  - Reset: state IDLE; byte_ready, mem_we, cpu_hold, busy, done, err = 0;
//    mem_addr, mem_wdata, word/byte counters = 0. Reset mid-load aborts at
//    once; no further writes; partially assembled word discarded.
//  - FSM: IDLE -start-> HDR_LO -byte-> HDR_HI -byte-> DATA -last byte-> [CSUM]
//    -> DONE -> IDLE (DONE lasts exactly 1 cycle, done=1 there).
//  - Header: N = {hi,lo}, 16 bits, little-endian. N==0: HDR_HI -> CSUM/DONE,
//    no writes. N>DEPTH: err=1, -> IDLE, no writes.
//  - byte_ready=1 in HDR_LO, HDR_HI, DATA, CSUM; 0 in IDLE, DONE.
//  - DATA: byte k of a word lands in bits [8k+7:8k] (first byte = [7:0]).
//    The cycle after the 4th byte: mem_we=1, mem_addr=word index,
//    mem_wdata=assembled word. Assembly register is separate from mem_wdata,
//    so byte_ready stays 1 during the write (1 byte/cycle sustained).
//  - Word index starts at 0, +1 per write, never wraps (bounded by N<=DEPTH).
//    After the last write, mem_addr holds N-1.
//  - Leave DATA when the 4*N-th byte is accepted; the final mem_we pulse
//    coincides with the first cycle of CSUM/DONE.
//  - cpu_hold = busy; it drops the cycle after DONE.
//  - start outside IDLE is ignored. byte_valid in IDLE/DONE is not accepted.
//  - err is cleared when start is accepted in IDLE.
// CONFIGURATION
//  IMEM_LOADER_CHECKSUM_EN defined: CSUM state present; one trailing byte is
//   expected, equal to the XOR of all 4*N payload bytes (header excluded).
//   Match -> DONE (done=1). Mismatch -> err=1, -> IDLE, done not pulsed.
//   Words already written stay written.
//  Undefined: no CSUM state; the last payload byte leads straight to DONE.
// TESTING
//  1 rst, start, bytes 02 00 | 78 56 34 12 | EF BE AD DE -> writes
//    0:0x12345678, 1:0xDEADBEEF; done pulse; cpu_hold low after DONE.
//  2 Header 00 00 -> no mem_we; done the cycle after HDR_HI (+1 byte CSUM=00
//    if IMEM_LOADER_CHECKSUM_EN).
//  3 Header 01 08 (N=2049) -> err=1, IDLE, no mem_we; next start clears err.
//  4 byte_valid held high with back-to-back bytes for N=3 -> one byte accepted
//    per cycle, exactly 3 mem_we pulses, addresses 0,1,2.
//  5 rst asserted after the 6th data byte of N=4 -> all outputs 0 next cycle;
//    only word 0 written.
//  6 CHECKSUM_EN: N=1, bytes 01 02 03 04, csum 05 -> err=1, no done;
//    csum 04 -> done=1.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: turns a byte stream into little-endian 32-bit
// words and writes them to the instruction RAM at word addresses 0..N-1.
// The stream starts with a 16-bit little-endian word count N, then 4*N
// payload bytes.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte, which is checked before done is pulsed.
module imem_loader #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DEPTH  = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    StIdle,
    StHdrLo,
    StHdrHi,
    StData,
`ifdef IMEM_LOADER_CHECKSUM_EN
    StCsum,
`endif
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [7:0]        hdr_lo_q, hdr_lo_d;
  logic [15:0]       n_q, n_d;
  logic [23:0]       asm_q, asm_d;   // lower three bytes of the word being built
  logic [1:0]        bcnt_q, bcnt_d;
  logic [15:0]       widx_q, widx_d; // words written so far
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        xfer;
  logic [15:0] n_new;
  logic [15:0] widx_inc;

  assign xfer     = byte_valid & byte_ready;
  assign n_new    = {byte_data, hdr_lo_q};
  assign widx_inc = widx_q + 16'd1;

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    byte_ready = 1'b0;
    unique case (state_q)
      StHdrLo, StHdrHi, StData: byte_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCsum:                   byte_ready = 1'b1;
`endif
      default:                  byte_ready = 1'b0;
    endcase
  end

  assign busy      = (state_q != StIdle);
  assign cpu_hold  = busy;
  assign done      = (state_q == StDone);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

  // Next-state logic: header decode, word assembly and RAM write generation.
  always_comb begin
    state_d     = state_q;
    hdr_lo_d    = hdr_lo_q;
    n_d         = n_q;
    asm_d       = asm_q;
    bcnt_d      = bcnt_q;
    widx_d      = widx_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          err_d   = 1'b0;
          asm_d   = '0;
          bcnt_d  = '0;
          widx_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
          state_d = StHdrLo;
        end
      end
      StHdrLo: begin
        if (xfer) begin
          hdr_lo_d = byte_data;
          state_d  = StHdrHi;
        end
      end
      StHdrHi: begin
        if (xfer) begin
          n_d = n_new;
          if ({1'b0, n_new} > 17'(DEPTH)) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else if (n_new == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = StCsum;
`else
            state_d = StDone;
`endif
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ byte_data;
`endif
          bcnt_d = bcnt_q + 2'd1;
          unique case (bcnt_q)
            2'd0: asm_d[7:0]   = byte_data;
            2'd1: asm_d[15:8]  = byte_data;
            2'd2: asm_d[23:16] = byte_data;
            default: begin
              // Fourth byte completes the word; assembly register is free again
              mem_we_d    = 1'b1;
              mem_addr_d  = widx_q[ADDR_W-1:0];
              mem_wdata_d = {byte_data, asm_q};
              widx_d      = widx_inc;
              if (widx_inc == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_d = StCsum;
`else
                state_d = StDone;
`endif
              end
            end
          endcase
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCsum: begin
        if (xfer) begin
          if (byte_data == csum_q) begin
            state_d = StDone;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
`endif
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset; reset drops any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      hdr_lo_q    <= '0;
      n_q         <= '0;
      asm_q       <= '0;
      bcnt_q      <= '0;
      widx_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hdr_lo_q    <= hdr_lo_d;
      n_q         <= n_d;
      asm_q       <= asm_d;
      bcnt_q      <= bcnt_d;
      widx_q      <= widx_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; follows IMEM_LOADER_CHECKSUM_EN if defined.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DEPTH  = 2048;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int stalls = 0;

  // Write/done log, sampled on the rising edge (registered outputs, old values).
  int          wr_n = 0;
  int          done_n = 0;
  logic [31:0] wr_addr [16];
  logic [31:0] wr_data [16];

  always @(posedge clk) begin
    if (mem_we) begin
      if (wr_n < 16) begin
        wr_addr[wr_n] <= 32'(mem_addr);
        wr_data[wr_n] <= mem_wdata;
      end
      wr_n <= wr_n + 1;
    end
    if (done) done_n <= done_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present a byte and return at the negedge after it is accepted.
  task automatic send(input logic [7:0] b);
    int waits;
    waits = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!byte_ready) check("send_ready", 32'(byte_ready), 32'd1);
    else @(negedge clk);
    stalls += waits;
  endtask

  task automatic idle_bus();
    byte_valid = 1'b0;
    byte_data  = 8'h00;
  endtask

  int wbase;
  int dbase;
  int sbase;

  initial begin
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    // Bytes offered in IDLE are not accepted
    byte_valid = 1'b1; byte_data = 8'hFF;
    @(negedge clk);
    check("idle_ready", 32'(byte_ready), 32'd0);
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    idle_bus();

    // Test 1: two words
    wbase = wr_n; dbase = done_n;
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_hold", 32'(cpu_hold), 32'd1);
    check("t1_ready", 32'(byte_ready), 32'd1);
    send(8'h02); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    check("t1_last_we", 32'(mem_we), 32'd1);
    check("t1_last_addr", 32'(mem_addr), 32'd1);
    check("t1_last_wdata", mem_wdata, 32'hDEADBEEF);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h2A);
`endif
    check("t1_done", 32'(done), 32'd1);
    check("t1_done_ready", 32'(byte_ready), 32'd0);
    check("t1_done_hold", 32'(cpu_hold), 32'd1);
    idle_bus();
    @(negedge clk);
    check("t1_done_drop", 32'(done), 32'd0);
    check("t1_hold_drop", 32'(cpu_hold), 32'd0);
    check("t1_busy_drop", 32'(busy), 32'd0);
    check("t1_addr_hold", 32'(mem_addr), 32'd1);
    check("t1_nwr", 32'(wr_n - wbase), 32'd2);
    check("t1_a0", wr_addr[wbase], 32'd0);
    check("t1_d0", wr_data[wbase], 32'h12345678);
    check("t1_a1", wr_addr[wbase+1], 32'd1);
    check("t1_d1", wr_data[wbase+1], 32'hDEADBEEF);
    check("t1_ndone", 32'(done_n - dbase), 32'd1);
    check("t1_err", 32'(err), 32'd0);

    // Test 2: empty image
    wbase = wr_n; dbase = done_n;
    pulse_start();
    send(8'h00); send(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    check("t2_done", 32'(done), 32'd1);
    idle_bus();
    @(negedge clk);
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_nwr", 32'(wr_n - wbase), 32'd0);
    check("t2_ndone", 32'(done_n - dbase), 32'd1);

    // Test 3: N = 2049 rejected
    wbase = wr_n; dbase = done_n;
    pulse_start();
    send(8'h01); send(8'h08);
    idle_bus();
    check("t3_err", 32'(err), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_ready", 32'(byte_ready), 32'd0);
    repeat (2) @(negedge clk);
    check("t3_err_sticky", 32'(err), 32'd1);
    check("t3_nwr", 32'(wr_n - wbase), 32'd0);
    check("t3_ndone", 32'(done_n - dbase), 32'd0);
    pulse_start();
    check("t3_err_clr", 32'(err), 32'd0);
    check("t3_busy2", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t3_rst_busy", 32'(busy), 32'd0);

    // Test 4: N = 3, back-to-back bytes
    wbase = wr_n; dbase = done_n;
    pulse_start();
    send(8'h03); send(8'h00);
    sbase = stalls;
    for (int i = 1; i <= 12; i++) send(8'(i));
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h0C);
`endif
    check("t4_stalls", 32'(stalls - sbase), 32'd0);
    check("t4_done", 32'(done), 32'd1);
    idle_bus();
    @(negedge clk);
    check("t4_nwr", 32'(wr_n - wbase), 32'd3);
    check("t4_a0", wr_addr[wbase], 32'd0);
    check("t4_a1", wr_addr[wbase+1], 32'd1);
    check("t4_a2", wr_addr[wbase+2], 32'd2);
    check("t4_d0", wr_data[wbase], 32'h04030201);
    check("t4_d1", wr_data[wbase+1], 32'h08070605);
    check("t4_d2", wr_data[wbase+2], 32'h0C0B0A09);
    check("t4_addr_hold", 32'(mem_addr), 32'd2);

    // Test 5: reset after the 6th data byte of N = 4
    wbase = wr_n; dbase = done_n;
    pulse_start();
    send(8'h04); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55); send(8'h66);
    rst = 1'b1;
    idle_bus();
    @(negedge clk);
    check("t5_we", 32'(mem_we), 32'd0);
    check("t5_addr", 32'(mem_addr), 32'd0);
    check("t5_wdata", mem_wdata, 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_hold", 32'(cpu_hold), 32'd0);
    check("t5_ready", 32'(byte_ready), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_err", 32'(err), 32'd0);
    rst = 1'b0;
    byte_valid = 1'b1; byte_data = 8'h77;
    repeat (4) @(negedge clk);
    idle_bus();
    check("t5_nwr", 32'(wr_n - wbase), 32'd1);
    check("t5_a0", wr_addr[wbase], 32'd0);
    check("t5_d0", wr_data[wbase], 32'h44332211);
    check("t5_ndone", 32'(done_n - dbase), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Test 6: checksum mismatch then match
    wbase = wr_n; dbase = done_n;
    pulse_start();
    send(8'h01); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h05);
    idle_bus();
    check("t6_bad_err", 32'(err), 32'd1);
    check("t6_bad_done", 32'(done), 32'd0);
    check("t6_bad_busy", 32'(busy), 32'd0);
    pulse_start();
    send(8'h01); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h04);
    check("t6_good_done", 32'(done), 32'd1);
    check("t6_good_err", 32'(err), 32'd0);
    idle_bus();
    @(negedge clk);
    check("t6_nwr", 32'(wr_n - wbase), 32'd2);
    check("t6_d0", wr_data[wbase], 32'h04030201);
    check("t6_ndone", 32'(done_n - dbase), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
